// File: rtl/huffman_dec_if.sv
// Bus bundle for huffman_dec: table load, serial code bits and decoded symbol outputs.
// master = producer of bits/tables (e.g. testbench), slave = the decoder itself.
interface huffman_dec_if;
    logic        code_valid;
    logic [47:0] HC;
    logic [47:0] M;
    logic        bit_valid;
    logic        bit_in;
    logic        flush;
    logic        ready;
    logic        sym_valid;
    logic [7:0]  sym;
    logic        err;
    logic [47:0] CNT;

    modport master (
        output code_valid, HC, M, bit_valid, bit_in, flush,
        input  ready, sym_valid, sym, err, CNT
    );

    modport slave (
        input  code_valid, HC, M, bit_valid, bit_in, flush,
        output ready, sym_valid, sym, err, CNT
    );
endinterface

// File: rtl/huffman_dec.sv
// Serial, MSB-first prefix-code decoder for six symbols with a loadable code/mask table.
// Define HUFFMAN_DEC_CNT_EN to build the per-symbol saturating decode counters on CNT.
module huffman_dec (
    input  logic         clk,
    input  logic         reset,
    huffman_dec_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, RUN, HALT} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [7:0]  r_code    [6];
    logic [7:0]  r_mask    [6];
    logic [3:0]  r_codeLen [6];
    logic [3:0]  r_maxLen;
    logic [7:0]  r_acc;
    logic [3:0]  r_len;
    logic        r_symValid;
    logic [7:0]  r_sym;
    logic        r_err;

    logic [3:0]  w_loadLen [6];
    logic [3:0]  w_loadMax;
    logic [7:0]  w_newAcc;
    logic [3:0]  w_newLen;
    logic        w_hit;
    logic [7:0]  w_hitSym;
    logic        w_load;
    logic [7:0]  w_accNext;
    logic [3:0]  w_lenNext;
    logic        w_symValidNext;
    logic [7:0]  w_symNext;
    logic        w_errNext;

    // A mask is usable only when it is a contiguous run of L low ones; anything else yields length 0.
    function automatic logic [3:0] maskLen(input logic [7:0] m);
        logic [3:0] l;
        logic [8:0] t;
        l = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            t = (9'd1 << i) - 9'd1;
            if (m == t[7:0]) l = 4'(i);
        end
        return l;
    endfunction

    always_comb begin
        w_loadMax = 4'd0;
        for (int k = 0; k < 6; k++) begin
            w_loadLen[k] = maskLen(bus.M[8*k +: 8]);
            if (w_loadLen[k] > w_loadMax) w_loadMax = w_loadLen[k];
        end
    end

    assign w_newAcc = {r_acc[6:0], bus.bit_in};
    assign w_newLen = r_len + 4'd1;

    // Scanning downward lets the lowest-numbered matching entry win.
    always_comb begin
        w_hit    = 1'b0;
        w_hitSym = 8'd0;
        for (int k = 5; k >= 0; k--) begin
            if (r_codeLen[k] != 4'd0 && w_newLen == r_codeLen[k] &&
                ((w_newAcc ^ r_code[k]) & r_mask[k]) == 8'd0) begin
                w_hit    = 1'b1;
                w_hitSym = 8'(k + 1);
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_load         = 1'b0;
        w_accNext      = r_acc;
        w_lenNext      = r_len;
        w_symValidNext = 1'b0;
        w_symNext      = r_sym;
        w_errNext      = 1'b0;
        if (bus.code_valid) begin
            w_load      = 1'b1;
            w_accNext   = 8'd0;
            w_lenNext   = 4'd0;
            w_stateNext = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.flush) begin
                        w_accNext = 8'd0;
                        w_lenNext = 4'd0;
                        w_errNext = (r_len != 4'd0);
                    end else if (bus.bit_valid) begin
                        if (w_hit) begin
                            w_symValidNext = 1'b1;
                            w_symNext      = w_hitSym;
                            w_accNext      = 8'd0;
                            w_lenNext      = 4'd0;
                        end else if (w_newLen >= r_maxLen) begin
                            w_errNext   = 1'b1;
                            w_accNext   = 8'd0;
                            w_lenNext   = 4'd0;
                            w_stateNext = HALT;
                        end else begin
                            w_accNext = w_newAcc;
                            w_lenNext = w_newLen;
                        end
                    end
                end
                HALT: begin
                    if (bus.flush) begin
                        w_accNext   = 8'd0;
                        w_lenNext   = 4'd0;
                        w_stateNext = RUN;
                    end
                end
                EMPTY:   w_stateNext = EMPTY;
                default: w_stateNext = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= EMPTY;
        else       r_state <= w_stateNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 6; k++) begin
                r_code[k]    <= 8'd0;
                r_mask[k]    <= 8'd0;
                r_codeLen[k] <= 4'd0;
            end
            r_maxLen   <= 4'd0;
            r_acc      <= 8'd0;
            r_len      <= 4'd0;
            r_symValid <= 1'b0;
            r_sym      <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_load) begin
                for (int k = 0; k < 6; k++) begin
                    r_code[k]    <= bus.HC[8*k +: 8];
                    r_mask[k]    <= bus.M[8*k +: 8];
                    r_codeLen[k] <= w_loadLen[k];
                end
                r_maxLen <= w_loadMax;
            end
            r_acc      <= w_accNext;
            r_len      <= w_lenNext;
            r_symValid <= w_symValidNext;
            r_sym      <= w_symNext;
            r_err      <= w_errNext;
        end
    end

    assign bus.ready     = (r_state == RUN);
    assign bus.sym_valid = r_symValid;
    assign bus.sym       = r_sym;
    assign bus.err       = r_err;

`ifdef HUFFMAN_DEC_CNT_EN
    logic [47:0] r_cnt;

    // Counts advance on the same edge that raises sym_valid, so CNT already includes the presented symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 48'd0;
        end else if (w_load) begin
            r_cnt <= 48'd0;
        end else if (w_symValidNext) begin
            for (int k = 0; k < 6; k++) begin
                if (w_symNext == 8'(k + 1) && r_cnt[8*k +: 8] != 8'hFF)
                    r_cnt[8*k +: 8] <= r_cnt[8*k +: 8] + 8'd1;
            end
        end
    end

    assign bus.CNT = r_cnt;
`else
    assign bus.CNT = 48'd0;
`endif
endmodule
